// File: rtl/shift_issue_stage.sv
// Decode/issue stage for the shift family feeding the barrel shifter.
// Decodes the R-type shift ops and queues control bundles in a 2-entry skid buffer.
module shift_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_count,
  output logic [1:0]            out_op,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  drop_pulse,
  output logic [CNT_WIDTH-1:0]  issued_cnt,
  output logic [CNT_WIDTH-1:0]  dropped_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] count;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t  state, state_nx;
  bundle_t main_q, skid_q, dec;
  logic    dec_ok, in_fire, out_fire, enq;
  logic    load_main, load_skid, skid_to_main;
  logic    unused;

  assign unused   = ^{instr[25:22], instr[20:16], rs_val[DATA_WIDTH-1:ADDR_WIDTH]};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign enq      = in_fire & dec_ok;

  // funct[2] selects the variable (register-count) forms; the low rs/sa bit
  // picks rotate over logical right for the SRL/SRLV encodings.
  always_comb begin
    dec        = '0;
    dec_ok     = 1'b0;
    dec.data   = rt_val;
    dec.rd     = ADDR_WIDTH'(instr[15:11]);
    dec.count  = instr[2] ? rs_val[ADDR_WIDTH-1:0] : ADDR_WIDTH'(instr[10:6]);
    case (instr[5:0])
      6'h00, 6'h04: begin dec.op = 2'd0;                   dec_ok = 1'b1; end
      6'h02:        begin dec.op = instr[21] ? 2'd3 : 2'd1; dec_ok = 1'b1; end
      6'h06:        begin dec.op = instr[6]  ? 2'd3 : 2'd1; dec_ok = 1'b1; end
      6'h03, 6'h07: begin dec.op = 2'd2;                   dec_ok = 1'b1; end
      default: ;
    endcase
    if (instr[31:26] != 6'd0 || instr[15:11] == 5'd0) dec_ok = 1'b0;
  end

  always_comb begin
    state_nx     = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: if (enq) begin load_main = 1'b1; state_nx = ONE; end
      ONE: begin
        if (enq && out_ready)  load_main = 1'b1;
        else if (enq)          begin load_skid = 1'b1; state_nx = FULL; end
        else if (out_ready)    state_nx = EMPTY;
      end
      FULL: if (out_ready) begin skid_to_main = 1'b1; state_nx = ONE; end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready    <= 1'b0;
      drop_pulse  <= 1'b0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      state      <= state_nx;
      if (load_main)         main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= dec;
      // registered ready mirrors the next state so no comb path reaches upstream
      in_ready   <= (state_nx != FULL);
      drop_pulse <= in_fire & ~dec_ok;
      if (out_fire && issued_cnt != '1)              issued_cnt  <= issued_cnt + 1'b1;
      if (in_fire && !dec_ok && dropped_cnt != '1)   dropped_cnt <= dropped_cnt + 1'b1;
    end
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q.data;
  assign out_count = main_q.count;
  assign out_op    = main_q.op;
  assign out_rd    = main_q.rd;

endmodule
